// File: rtl/mem_sram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between a read/write
// host port (A) and a read-only port (B), with bounded bursts and tagged read return.
module mem_sram_arbiter #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_a,
  input  logic                 we_a,
  input  logic [ADDR_BITS-1:0] addr_a,
  input  logic [DATA_BITS-1:0] wdata_a,
  output logic                 gnt_a,
  output logic                 rvalid_a,
  output logic [DATA_BITS-1:0] rdata_a,
  input  logic                 req_b,
  input  logic [ADDR_BITS-1:0] addr_b,
  output logic                 gnt_b,
  output logic                 rvalid_b,
  output logic [DATA_BITS-1:0] rdata_b,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_din,
  input  logic [DATA_BITS-1:0] mem_dout
);

  typedef enum logic {OWN_A, OWN_B} owner_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_A, TAG_B} tag_e;

  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

  owner_e     owner_q, owner_d, winner;
  logic [7:0] cnt_q, cnt_d;
  tag_e       tag_q, tag_d;
  logic       grant_a, grant_b;

  // Grants are gated by rst_n so nothing reaches the SRAM while reset is held.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n) begin
      if (req_a && req_b) begin
        if (cnt_q < BURST_MAX) begin
          grant_a = (owner_q == OWN_A);
          grant_b = (owner_q == OWN_B);
        end else begin
          grant_a = (owner_q == OWN_B);
          grant_b = (owner_q == OWN_A);
        end
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
  end

  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    tag_d   = TAG_NONE;
    winner  = grant_a ? OWN_A : OWN_B;
    if (grant_a || grant_b) begin
      if (winner == owner_q) begin
        cnt_d = (cnt_q < BURST_MAX) ? cnt_q + 8'd1 : BURST_MAX;
      end else begin
        owner_d = winner;
        cnt_d   = 8'd1;
      end
    end
    if (grant_a && !we_a) begin
      tag_d = TAG_A;
    end else if (grant_b) begin
      tag_d = TAG_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_A;
      cnt_q   <= '0;
      tag_q   <= TAG_NONE;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (grant_a) begin
      mem_we   = we_a;
      mem_addr = addr_a;
      mem_din  = wdata_a;
    end else if (grant_b) begin
      mem_addr = addr_b;
    end
  end

  assign gnt_a    = grant_a;
  assign gnt_b    = grant_b;
  assign rvalid_a = (tag_q == TAG_A);
  assign rvalid_b = (tag_q == TAG_B);
  assign rdata_a  = rvalid_a ? mem_dout : '0;
  assign rdata_b  = rvalid_b ? mem_dout : '0;

endmodule

// File: tb/tb_mem_sram_arbiter.sv
// Directed bench for mem_sram_arbiter: table of per-cycle vectors plus hand-written
// reset-in-flight and BURST_LEN=1 alternation sequences.
module tb_mem_sram_arbiter;

  logic        clk, rst_n;
  logic        req_a, we_a, req_b;
  logic [15:0] addr_a, addr_b;
  logic [7:0]  wdata_a;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b, mem_we;
  logic [7:0]  rdata_a, rdata_b, mem_din, mem_dout;
  logic [15:0] mem_addr;
  logic        gnt_a1, gnt_b1, rvalid_a1, rvalid_b1, mem_we1;
  logic [7:0]  rdata_a1, rdata_b1, mem_din1, mem_dout1;
  logic [15:0] mem_addr1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sram [65536];

  mem_sram_arbiter #(.ADDR_BITS(16), .DATA_BITS(8), .BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .addr_b(addr_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  mem_sram_arbiter #(.ADDR_BITS(16), .DATA_BITS(8), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a1), .rvalid_a(rvalid_a1), .rdata_a(rdata_a1),
    .req_b(req_b), .addr_b(addr_b),
    .gnt_b(gnt_b1), .rvalid_b(rvalid_b1), .rdata_b(rdata_b1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_dout(mem_dout1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: 1-cycle registered read, write visible to the next cycle's read.
  initial begin
    for (int unsigned i = 0; i < 65536; i++) sram[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
  end
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_din;
    mem_dout <= sram[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        rst_n, req_a, we_a, req_b;
    logic [15:0] addr_a, addr_b;
    logic [7:0]  wdata_a;
    logic        gnt_a, gnt_b, mem_we, rvalid_a, rvalid_b;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din, rdata_a, rdata_b;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int rn, input int ra, input int wa, input int aa, input int wd,
                     input int rb, input int ab,
                     input int ga, input int gb, input int mw, input int ma, input int md,
                     input int va, input int da, input int vb, input int db);
    vec_t v;
    v.rst_n = 1'(rn); v.req_a = 1'(ra); v.we_a = 1'(wa); v.addr_a = 16'(aa);
    v.wdata_a = 8'(wd); v.req_b = 1'(rb); v.addr_b = 16'(ab);
    v.gnt_a = 1'(ga); v.gnt_b = 1'(gb); v.mem_we = 1'(mw); v.mem_addr = 16'(ma);
    v.mem_din = 8'(md); v.rvalid_a = 1'(va); v.rdata_a = 8'(da);
    v.rvalid_b = 1'(vb); v.rdata_b = 8'(db);
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_a = 1'b0; we_a = 1'b0; req_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; mem_dout1 = '0;

    // Reset with both requesting a write, then first grant after release goes to A
    add(0,1,1,'h0055,'h77,1,'h0066, 0,0,0,'h0000,'h00, 0,'h00,0,'h00);
    add(1,1,1,'h0055,'h77,1,'h0066, 1,0,1,'h0055,'h77, 0,'h00,0,'h00);
    // A writes 0xA5 to 0x0010 then reads it back
    add(0,0,0,'h0000,'h00,0,'h0000, 0,0,0,'h0000,'h00, 0,'h00,0,'h00);
    add(1,1,1,'h0010,'hA5,0,'h0000, 1,0,1,'h0010,'hA5, 0,'h00,0,'h00);
    add(1,1,0,'h0010,'h5A,0,'h0000, 1,0,0,'h0010,'h5A, 0,'h00,0,'h00);
    add(1,0,0,'h0000,'h00,0,'h0000, 0,0,0,'h0000,'h00, 1,'hA5,0,'h00);
    add(1,0,0,'h0000,'h00,0,'h0000, 0,0,0,'h0000,'h00, 0,'h00,0,'h00);
    // Contended reads from reset: A x4, B x4, A ...
    add(0,0,0,'h0000,'h00,0,'h0000, 0,0,0,'h0000,'h00, 0,'h00,0,'h00);
    add(1,1,0,'h0100,'h00,1,'h0200, 1,0,0,'h0100,'h00, 0,'h00,0,'h00);
    add(1,1,0,'h0100,'h00,1,'h0200, 1,0,0,'h0100,'h00, 1,'h3D,0,'h00);
    add(1,1,0,'h0100,'h00,1,'h0200, 1,0,0,'h0100,'h00, 1,'h3D,0,'h00);
    add(1,1,0,'h0100,'h00,1,'h0200, 1,0,0,'h0100,'h00, 1,'h3D,0,'h00);
    add(1,1,0,'h0100,'h00,1,'h0200, 0,1,0,'h0200,'h00, 1,'h3D,0,'h00);
    add(1,1,0,'h0100,'h00,1,'h0200, 0,1,0,'h0200,'h00, 0,'h00,1,'h3E);
    add(1,1,0,'h0100,'h00,1,'h0200, 0,1,0,'h0200,'h00, 0,'h00,1,'h3E);
    add(1,1,0,'h0100,'h00,1,'h0200, 0,1,0,'h0200,'h00, 0,'h00,1,'h3E);
    add(1,1,0,'h0100,'h00,1,'h0200, 1,0,0,'h0100,'h00, 0,'h00,1,'h3E);
    add(1,1,0,'h0100,'h00,1,'h0200, 1,0,0,'h0100,'h00, 1,'h3D,0,'h00);
    add(1,0,0,'h0000,'h00,0,'h0000, 0,0,0,'h0000,'h00, 1,'h3D,0,'h00);
    // A streams solo for 10 cycles, then B wins the first contested cycle
    add(0,0,0,'h0000,'h00,0,'h0000, 0,0,0,'h0000,'h00, 0,'h00,0,'h00);
    add(1,1,0,'h0300,'h00,0,'h0000, 1,0,0,'h0300,'h00, 0,'h00,0,'h00);
    for (int i = 0; i < 9; i++)
      add(1,1,0,'h0300,'h00,0,'h0000, 1,0,0,'h0300,'h00, 1,'h3F,0,'h00);
    add(1,1,0,'h0300,'h00,1,'h0400, 0,1,0,'h0400,'h00, 1,'h3F,0,'h00);
    add(1,1,0,'h0300,'h00,1,'h0400, 0,1,0,'h0400,'h00, 0,'h00,1,'h38);
    add(1,1,0,'h0300,'h00,1,'h0400, 0,1,0,'h0400,'h00, 0,'h00,1,'h38);
    add(1,1,0,'h0300,'h00,1,'h0400, 0,1,0,'h0400,'h00, 0,'h00,1,'h38);
    add(1,1,0,'h0300,'h00,1,'h0400, 1,0,0,'h0300,'h00, 0,'h00,1,'h38);
    add(1,0,0,'h0000,'h00,0,'h0000, 0,0,0,'h0000,'h00, 1,'h3F,0,'h00);
    // Write by A at N, read of the same address by B at N+1
    add(0,0,0,'h0000,'h00,0,'h0000, 0,0,0,'h0000,'h00, 0,'h00,0,'h00);
    add(1,1,1,'h1234,'h11,0,'h0000, 1,0,1,'h1234,'h11, 0,'h00,0,'h00);
    add(1,1,1,'h1234,'h22,0,'h0000, 1,0,1,'h1234,'h22, 0,'h00,0,'h00);
    add(1,0,0,'h0000,'h00,1,'h1234, 0,1,0,'h1234,'h00, 0,'h00,0,'h00);
    add(1,0,0,'h0000,'h00,0,'h0000, 0,0,0,'h0000,'h00, 0,'h00,1,'h22);

    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = vq[i].rst_n; req_a = vq[i].req_a; we_a = vq[i].we_a;
      addr_a = vq[i].addr_a; wdata_a = vq[i].wdata_a;
      req_b = vq[i].req_b; addr_b = vq[i].addr_b;
      #2;
      check("gnt_a",    i, 16'(gnt_a),    16'(vq[i].gnt_a));
      check("gnt_b",    i, 16'(gnt_b),    16'(vq[i].gnt_b));
      check("mem_we",   i, 16'(mem_we),   16'(vq[i].mem_we));
      check("mem_addr", i, mem_addr,      vq[i].mem_addr);
      check("mem_din",  i, 16'(mem_din),  16'(vq[i].mem_din));
      check("rvalid_a", i, 16'(rvalid_a), 16'(vq[i].rvalid_a));
      check("rdata_a",  i, 16'(rdata_a),  16'(vq[i].rdata_a));
      check("rvalid_b", i, 16'(rvalid_b), 16'(vq[i].rvalid_b));
      check("rdata_b",  i, 16'(rdata_b),  16'(vq[i].rdata_b));
    end

    // B owns the SRAM, then reset lands while a B read is in flight
    @(negedge clk);
    rst_n = 1'b0; req_a = 1'b0; we_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; req_b = 1'b1; addr_b = 16'h0500;
    #2;
    check("s6_gnt_b_first", 0, 16'(gnt_b), 16'd1);
    @(negedge clk);
    #2;
    check("s6_gnt_b_inflight", 0, 16'(gnt_b), 16'd1);
    check("s6_rvalid_b_prev", 0, 16'(rvalid_b), 16'd1);
    check("s6_rdata_b_prev", 0, 16'(rdata_b), 16'h0039);
    #1 rst_n = 1'b0;
    #1;
    check("s6_gnt_b_in_reset", 0, 16'(gnt_b), 16'd0);
    check("s6_rvalid_b_cleared", 0, 16'(rvalid_b), 16'd0);
    check("s6_rdata_b_cleared", 0, 16'(rdata_b), 16'd0);
    @(negedge clk);
    #2;
    check("s6_rvalid_b_no_replay", 0, 16'(rvalid_b), 16'd0);
    check("s6_gnt_a_in_reset", 0, 16'(gnt_a), 16'd0);

    // After release both contend; BURST_LEN=4 bursts in fours, BURST_LEN=1 alternates
    @(negedge clk);
    rst_n = 1'b1; req_a = 1'b1; we_a = 1'b0; addr_a = 16'h0100;
    for (int i = 0; i < 10; i++) begin
      #2;
      check("s6_gnt_a",    i, 16'(gnt_a),    16'((i < 4) || (i >= 8)));
      check("s6_gnt_b",    i, 16'(gnt_b),    16'((i >= 4) && (i < 8)));
      check("s6_rvalid_b", i, 16'(rvalid_b), 16'((i >= 5) && (i <= 8)));
      check("bl1_gnt_a",   i, 16'(gnt_a1),   16'(i % 2 == 0));
      check("bl1_gnt_b",   i, 16'(gnt_b1),   16'(i % 2 == 1));
      @(negedge clk);
    end
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
